// File: rtl/mult_taint_pkg.sv
// mult_taint_pkg: shared state encoding and taint smear helper for the radix taint multiplier
package mult_taint_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SMEAR_W = 128;
  // Prefix-OR from LSB toward MSB: bit j is set when any bit at or below j is set.
  function automatic logic [SMEAR_W-1:0] smear_up(input logic [SMEAR_W-1:0] v);
    logic [SMEAR_W-1:0] r;
    r[0] = v[0];
    for (int j = 1; j < SMEAR_W; j++) r[j] = r[j-1] | v[j];
    return r;
  endfunction
endpackage

// File: rtl/multiplier_radix_taint_dpath.sv
// multiplier_radix_taint_dpath: operand/accumulator registers and one radix step with taint shadow
module multiplier_radix_taint_dpath
  import mult_taint_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2,
  parameter int CW         = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [CW-1:0]      idx,
  input  logic [WIDTH-1:0]   mr_in,
  input  logic [WIDTH-1:0]   mr_t_in,
  input  logic [WIDTH-1:0]   md_in,
  input  logic [WIDTH-1:0]   md_t_in,
  output logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] acc_t
);
  logic [WIDTH-1:0]      mr, mr_t, md, md_t;
  logic [RADIX_BITS-1:0] d, d_t;
  logic [2*WIDTH-1:0]    pp, pp_t, pp_sh, pp_t_sh, md_sm, acc_t_nxt;
  assign d   = mr[RADIX_BITS-1:0];
  assign d_t = mr_t[RADIX_BITS-1:0];
  // One digit's partial product plus its taint; a tainted digit taints the whole partial product,
  // an untainted nonzero digit inherits multiplicand taint smeared upward through the carries.
  always_comb begin
    pp        = {{WIDTH{1'b0}}, md} * {{(2*WIDTH-RADIX_BITS){1'b0}}, d};
    md_sm     = (2*WIDTH)'(smear_up(SMEAR_W'(md_t)));
    pp_t      = {2*WIDTH{|d_t}} | ({2*WIDTH{|d}} & md_sm);
    pp_sh     = pp << (idx * RADIX_BITS);
    pp_t_sh   = pp_t << (idx * RADIX_BITS);
    acc_t_nxt = (2*WIDTH)'(smear_up(SMEAR_W'(acc_t | pp_t_sh)));
  end
  // Capture operands on an accepted start, then retire one digit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mr    <= '0;
      mr_t  <= '0;
      md    <= '0;
      md_t  <= '0;
      acc   <= '0;
      acc_t <= '0;
    end else if (load) begin
      mr    <= mr_in;
      mr_t  <= mr_t_in;
      md    <= md_in;
      md_t  <= md_t_in;
      acc   <= '0;
      acc_t <= '0;
    end else if (step) begin
      acc   <= acc + pp_sh;
      acc_t <= acc_t_nxt;
      mr    <= mr >> RADIX_BITS;
      mr_t  <= mr_t >> RADIX_BITS;
    end
  end
endmodule

// File: rtl/multiplier_radix_taint_track.sv
// multiplier_radix_taint_track: constant-time radix shift-add multiplier with bitwise taint tracking
module multiplier_radix_taint_track
  import mult_taint_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               start_t,
  input  logic               ack,
  input  logic               ack_t,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplier_t,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplicand_t,
  output logic [2*WIDTH-1:0] product,
  output logic [2*WIDTH-1:0] product_t,
  output logic               busy,
  output logic               busy_t,
  output logic               done,
  output logic               done_t
);
  localparam int ITERS = WIDTH / RADIX_BITS;
  localparam int CW    = ITERS > 1 ? $clog2(ITERS) : 1;
  if (WIDTH % RADIX_BITS != 0) begin : g_bad_radix
    $error("RADIX_BITS must divide WIDTH");
  end
  if (2 * WIDTH > SMEAR_W) begin : g_too_wide
    $error("2*WIDTH exceeds smear helper width");
  end
  state_t        state;
  logic [CW-1:0] cnt;
  logic          ctrl_t;
  logic [2*WIDTH-1:0] acc, acc_t;
  // Fixed-length sequencing and control taint; a clean ack kills control taint since the
  // operation length never depends on data, so control flow has reconverged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ctrl_t <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ctrl_t <= ctrl_t | start_t;
          if (start) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          state <= cnt == CW'(ITERS - 1) ? DONE : RUN;
          cnt   <= cnt + CW'(1);
        end
        DONE: begin
          ctrl_t <= (ack && !ack_t) ? 1'b0 : ctrl_t | ack_t;
          if (ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  multiplier_radix_taint_dpath #(
    .WIDTH(WIDTH),
    .RADIX_BITS(RADIX_BITS),
    .CW(CW)
  ) u_dpath (
    .clk(clk),
    .rst_n(rst_n),
    .load(state == IDLE && start),
    .step(state == RUN),
    .idx(cnt),
    .mr_in(multiplier),
    .mr_t_in(multiplier_t),
    .md_in(multiplicand),
    .md_t_in(multiplicand_t),
    .acc(acc),
    .acc_t(acc_t)
  );
  assign product   = acc;
  assign product_t = acc_t | {2*WIDTH{ctrl_t}};
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign busy_t    = ctrl_t;
  assign done_t    = ctrl_t;
endmodule

// File: tb/tb_multiplier_radix_taint_track.sv
// tb_multiplier_radix_taint_track: randomized and directed checks against a digit-level reference model
module tb_multiplier_radix_taint_track;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic s8 = 0, st8 = 0, k8 = 0, kt8 = 0;
  logic [7:0] a8 = 0, at8 = 0, b8 = 0, bt8 = 0;
  logic [15:0] p8, pt8;
  logic bz8, bzt8, dn8, dnt8;
  logic s16 = 0, st16 = 0, k16 = 0, kt16 = 0;
  logic [15:0] a16 = 0, at16 = 0, b16 = 0, bt16 = 0;
  logic [31:0] p16, pt16;
  logic bz16, bzt16, dn16, dnt16;
  int checks = 0, errors = 0;

  multiplier_radix_taint_track #(.WIDTH(8), .RADIX_BITS(2)) u8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .start_t(st8), .ack(k8), .ack_t(kt8),
    .multiplier(a8), .multiplier_t(at8), .multiplicand(b8), .multiplicand_t(bt8),
    .product(p8), .product_t(pt8), .busy(bz8), .busy_t(bzt8), .done(dn8), .done_t(dnt8));

  multiplier_radix_taint_track #(.WIDTH(16), .RADIX_BITS(4)) u16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .start_t(st16), .ack(k16), .ack_t(kt16),
    .multiplier(a16), .multiplier_t(at16), .multiplicand(b16), .multiplicand_t(bt16),
    .product(p16), .product_t(pt16), .busy(bz16), .busy_t(bzt16), .done(dn16), .done_t(dnt16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] por(input logic [63:0] v);
    logic [63:0] o = '0;
    logic run = 1'b0;
    for (int j = 0; j < 64; j++) begin
      run = run | v[j];
      o[j] = run;
    end
    return o;
  endfunction

  // Expected data taint: walk the multiplier digit by digit, OR each digit's taint footprint into
  // the running accumulator taint and let it spread toward the MSB.
  function automatic logic [63:0] m_taint(input int w, input int r, input logic [63:0] a,
                                          input logic [63:0] at, input logic [63:0] bt);
    logic [63:0] msk = (64'd1 << (2 * w)) - 1;
    logic [63:0] dm = (64'd1 << r) - 1;
    logic [63:0] acc = '0, pp, d, dt;
    for (int i = 0; i < w / r; i++) begin
      d  = (a >> (i * r)) & dm;
      dt = (at >> (i * r)) & dm;
      pp = dt != 0 ? msk : (d != 0 ? por(bt) : 64'd0);
      acc = por(acc | ((pp << (i * r)) & msk)) & msk;
    end
    return acc;
  endfunction

  function automatic logic [63:0] g_prod(input int sel);  return sel == 8 ? 64'(p8) : 64'(p16); endfunction
  function automatic logic [63:0] g_prodt(input int sel); return sel == 8 ? 64'(pt8) : 64'(pt16); endfunction
  function automatic logic g_busy(input int sel);  return sel == 8 ? bz8 : bz16; endfunction
  function automatic logic g_busyt(input int sel); return sel == 8 ? bzt8 : bzt16; endfunction
  function automatic logic g_done(input int sel);  return sel == 8 ? dn8 : dn16; endfunction
  function automatic logic g_donet(input int sel); return sel == 8 ? dnt8 : dnt16; endfunction

  task automatic drv(input int sel, input logic s, input logic st, input logic [15:0] a,
                     input logic [15:0] at, input logic [15:0] b, input logic [15:0] bt);
    if (sel == 8) begin
      s8 = s; st8 = st; a8 = a[7:0]; at8 = at[7:0]; b8 = b[7:0]; bt8 = bt[7:0];
    end else begin
      s16 = s; st16 = st; a16 = a; at16 = at; b16 = b; bt16 = bt;
    end
  endtask

  task automatic ackd(input int sel, input logic k, input logic kt);
    if (sel == 8) begin k8 = k; kt8 = kt; end
    else begin k16 = k; kt16 = kt; end
  endtask

  task automatic op(input int sel, input logic [15:0] a_i, input logic [15:0] at_i,
                    input logic [15:0] b_i, input logic [15:0] bt_i,
                    input logic st, input logic kt, input logic poke);
    int w = sel;
    int r = sel == 8 ? 2 : 4;
    int n = 0;
    logic [63:0] wm = (64'd1 << w) - 1;
    logic [63:0] msk = (64'd1 << (2 * w)) - 1;
    logic [63:0] a = 64'(a_i) & wm, at = 64'(at_i) & wm, b = 64'(b_i) & wm, bt = 64'(bt_i) & wm;
    logic [63:0] ep = a * b;
    logic [63:0] et = m_taint(w, r, a, at, bt) | (st ? msk : 64'd0);
    @(negedge clk);
    drv(sel, 1, st, a_i, at_i, b_i, bt_i);
    @(posedge clk); #1;
    drv(sel, 0, 0, ~a_i, 16'h0, ~b_i, 16'h0);
    chk("busy_after_start", 64'(g_busy(sel)), 64'd1);
    chk("busy_t_after_start", 64'(g_busyt(sel)), 64'(st));
    while (!g_done(sel) && n < 50) begin
      if (poke && n == 1) begin
        drv(sel, 1, 0, 16'h5a5a, 16'h0, 16'h3c3c, 16'h0);
        ackd(sel, 1, 0);
      end
      if (poke && n == 2) begin
        drv(sel, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
        ackd(sel, 0, 0);
      end
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(w / r));
    chk("product", g_prod(sel), ep);
    chk("product_t", g_prodt(sel), et);
    chk("done_t", 64'(g_donet(sel)), 64'(st));
    @(posedge clk); #1;
    chk("done_hold", 64'(g_done(sel)), 64'd1);
    chk("product_hold", g_prod(sel), ep);
    ackd(sel, 1, kt);
    drv(sel, 1, 0, a_i, 16'h0, b_i, 16'h0);
    @(posedge clk); #1;
    ackd(sel, 0, 0);
    drv(sel, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("idle_after_ack", 64'(g_busy(sel)), 64'd0);
    chk("busy_t_after_ack", 64'(g_busyt(sel)), 64'(kt));
    @(posedge clk); #1;
    chk("start_ignored_in_done", 64'(g_busy(sel)), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy8"}, 64'(bz8), 64'd0);
    chk({tag, "_done8"}, 64'(dn8), 64'd0);
    chk({tag, "_busy_t8"}, 64'(bzt8), 64'd0);
    chk({tag, "_prod8"}, 64'(p8), 64'd0);
    chk({tag, "_prod_t8"}, 64'(pt8), 64'd0);
    chk({tag, "_busy16"}, 64'(bz16), 64'd0);
    chk({tag, "_prod_t16"}, 64'(pt16), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1;
    op(8, 16'd13, 16'h0, 16'd11, 16'h0, 0, 0, 0);
    chk("basic_143", 64'(p8), 64'd143);
    op(8, 16'd0, 16'h0, 16'd255, 16'h0, 0, 0, 0);
    op(8, 16'd255, 16'h0, 16'd255, 16'h0, 0, 0, 0);
    chk("max_65025", 64'(p8), 64'd65025);
    op(8, 16'd13, 16'h04, 16'd11, 16'h0, 0, 0, 0);
    op(8, 16'($urandom_range(0, 255)), 16'h0, 16'($urandom_range(0, 255)), 16'h0, 1, 0, 0);
    op(8, 16'd200, 16'h0, 16'd77, 16'h10, 0, 0, 1);
    for (int i = 0; i < 20; i++)
      op(8, 16'($urandom), 16'($urandom) & 16'($urandom), 16'($urandom),
         16'($urandom) & 16'($urandom) & 16'($urandom), 0, 0, 0);
    op(16, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 0, 0, 0);
    chk("w16_ffff", 64'(p16), 64'hFFFE0001);
    for (int i = 0; i < 6; i++)
      op(16, 16'($urandom), 16'($urandom) & 16'($urandom) & 16'($urandom), 16'($urandom),
         16'($urandom) & 16'($urandom) & 16'($urandom), 0, 0, 0);
    op(8, 16'd7, 16'h0, 16'd9, 16'h0, 0, 1, 0);
    @(negedge clk);
    drv(8, 1, 1, 16'd99, 16'h0, 16'd45, 16'h0);
    @(posedge clk); #1;
    drv(8, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
    @(posedge clk);
    @(posedge clk); #1;
    chk("busy_mid_run", 64'(bz8), 64'd1);
    rst_n = 0;
    #1;
    chk_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1;
    op(8, 16'd99, 16'h0, 16'd45, 16'h0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
